// File: rtl/float_copro_issue_if.sv
// Bus bundle between the LM32 pipeline, the FP issue block and the coprocessor.
// master = issue block view; slave = environment (pipeline + coprocessor) view.
interface float_copro_issue_if #(
   parameter int OPC_W  = 11,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [OPC_W-1:0]  req_opcode;
   logic [DATA_W-1:0] req_op0;
   logic [DATA_W-1:0] req_op1;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_err;
   logic              copro_valid;
   logic              copro_accept;
   logic [OPC_W-1:0]  copro_opcode;
   logic [DATA_W-1:0] copro_op0;
   logic [DATA_W-1:0] copro_op1;
   logic              copro_complete;
   logic [DATA_W-1:0] copro_result;

   modport master (
      input  req_valid, req_opcode, req_op0, req_op1, rsp_ready,
             copro_complete, copro_result,
      output req_ready, rsp_valid, rsp_result, rsp_err,
             copro_valid, copro_accept, copro_opcode, copro_op0, copro_op1
   );

   modport slave (
      output req_valid, req_opcode, req_op0, req_op1, rsp_ready,
             copro_complete, copro_result,
      input  req_ready, rsp_valid, rsp_result, rsp_err,
             copro_valid, copro_accept, copro_opcode, copro_op0, copro_op1
   );
endinterface

// File: rtl/float_copro_issue.sv
// CPU-side initiator for the FP coprocessor valid/complete/accept handshake.
// Optional macro FLOAT_COPRO_PERF_EN adds perf_ops / perf_cycles counters.
module float_copro_issue #(
   parameter int TIMEOUT = 64,
   parameter int OPC_W   = 11,
   parameter int DATA_W  = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   float_copro_issue_if.master bus
`ifdef FLOAT_COPRO_PERF_EN
   ,
   output logic [31:0]         perf_ops,
   output logic [31:0]         perf_cycles
`endif
);
   localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit               TMO_EN   = (TIMEOUT != 0);

   typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_WAIT, S_ACK, S_RESP} state_t;

   state_t            r_state, w_state_nx;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              r_req_ready, w_req_ready;
   logic              r_rsp_valid, w_rsp_valid;
   logic [DATA_W-1:0] r_rsp_result, w_rsp_result;
   logic              r_rsp_err, w_rsp_err;
   logic              r_copro_valid, w_copro_valid;
   logic              r_copro_accept, w_copro_accept;
   logic [OPC_W-1:0]  r_opcode, w_opcode;
   logic [DATA_W-1:0] r_op0, w_op0;
   logic [DATA_W-1:0] r_op1, w_op1;

   // Outputs are decoded from the next state so every port comes straight off a flop.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      w_state_nx     = r_state;
      w_cnt          = r_cnt;
      w_req_ready    = 1'b0;
      w_rsp_valid    = 1'b0;
      w_rsp_result   = r_rsp_result;
      w_rsp_err      = r_rsp_err;
      w_copro_valid  = 1'b0;
      w_copro_accept = 1'b0;
      w_opcode       = r_opcode;
      w_op0          = r_op0;
      w_op1          = r_op1;
      case (r_state)
         S_FLUSH: begin
            // The coprocessor has no reset: pulse accept once before serving requests.
            if (r_copro_accept) begin
               w_state_nx  = S_IDLE;
               w_req_ready = 1'b1;
            end else begin
               w_copro_accept = 1'b1;
            end
         end
         S_IDLE: begin
            if (bus.req_valid) begin
               w_opcode      = bus.req_opcode;
               w_op0         = bus.req_op0;
               w_op1         = bus.req_op1;
               w_cnt         = '0;
               w_copro_valid = 1'b1;
               w_state_nx    = S_WAIT;
            end else begin
               w_req_ready = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.copro_complete) begin
               w_rsp_result   = bus.copro_result;
               w_rsp_err      = 1'b0;
               w_copro_accept = 1'b1;
               w_state_nx     = S_ACK;
            end else if (TMO_EN && (r_cnt == CNT_LAST)) begin
               w_rsp_result   = '0;
               w_rsp_err      = 1'b1;
               w_copro_accept = 1'b1;
               w_state_nx     = S_ACK;
            end else begin
               w_copro_valid = 1'b1;
               if (r_cnt != '1) w_cnt = r_cnt + 1'b1;
            end
         end
         S_ACK: begin
            w_rsp_valid = 1'b1;
            w_state_nx  = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_req_ready = 1'b1;
               w_state_nx  = S_IDLE;
            end else begin
               w_rsp_valid = 1'b1;
            end
         end
         default: w_state_nx = S_FLUSH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: synchronous reset; all state uses <= so every flop updates from pre-edge values.
      if (!rst_n) begin
         r_state        <= S_FLUSH;
         r_cnt          <= '0;
         r_req_ready    <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_result   <= '0;
         r_rsp_err      <= 1'b0;
         r_copro_valid  <= 1'b0;
         r_copro_accept <= 1'b0;
         r_opcode       <= '0;
         r_op0          <= '0;
         r_op1          <= '0;
      end else begin
         r_state        <= w_state_nx;
         r_cnt          <= w_cnt;
         r_req_ready    <= w_req_ready;
         r_rsp_valid    <= w_rsp_valid;
         r_rsp_result   <= w_rsp_result;
         r_rsp_err      <= w_rsp_err;
         r_copro_valid  <= w_copro_valid;
         r_copro_accept <= w_copro_accept;
         r_opcode       <= w_opcode;
         r_op0          <= w_op0;
         r_op1          <= w_op1;
      end
   end

   assign bus.req_ready    = r_req_ready;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_result   = r_rsp_result;
   assign bus.rsp_err      = r_rsp_err;
   assign bus.copro_valid  = r_copro_valid;
   assign bus.copro_accept = r_copro_accept;
   assign bus.copro_opcode = r_opcode;
   assign bus.copro_op0    = r_op0;
   assign bus.copro_op1    = r_op1;

`ifdef FLOAT_COPRO_PERF_EN
   logic [31:0] r_perf_ops, r_perf_cycles;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_ops    <= '0;
         r_perf_cycles <= '0;
      end else if (r_state == S_WAIT) begin
         r_perf_cycles <= r_perf_cycles + 32'd1;
         if (bus.copro_complete) r_perf_ops <= r_perf_ops + 32'd1;
      end
   end

   assign perf_ops    = r_perf_ops;
   assign perf_cycles = r_perf_cycles;
`endif
endmodule

// File: doc/float_copro_issue.md
Name: float_copro_issue

Overview:
CPU-side initiator for the floating-point coprocessor handshake (copro_valid / copro_complete / copro_accept).
- Accepts one operation at a time from the LM32 pipeline over a valid/ready request channel.
- Drives the coprocessor and waits for completion, with an optional timeout.
- Returns the result over a valid/ready response channel and releases the coprocessor with a one-cycle accept pulse.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before aborting; 0 disables the timeout.
OPC_W, 11, opcode width.
DATA_W, 32, operand/result width.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline presents an operation
req_ready  out  1  block can take an operation (high only in IDLE)
req_opcode  in  OPC_W  0=add 1=sub 2=mul 3=div, others passed through unchanged
req_op0  in  DATA_W  operand 0 (IEEE-754 single)
req_op1  in  DATA_W  operand 1
rsp_valid  out  1  result available
rsp_ready  in  1  pipeline takes result
rsp_result  out  DATA_W  result word
rsp_err  out  1  result produced by timeout abort
copro_valid  out  1  request to coprocessor
copro_accept  out  1  one-cycle release pulse to coprocessor
copro_opcode  out  OPC_W  registered opcode
copro_op0  out  DATA_W  registered operand 0
copro_op1  out  DATA_W  registered operand 1
copro_complete  in  1  coprocessor result valid; held until accept
copro_result  in  DATA_W  coprocessor result

Behaviour:
- All outputs are registered. While rst_n=0 every output is 0 and state is FLUSH.
- States and transitions:
  - FLUSH: first cycle after reset; copro_accept=1, copro_valid=0. Clears any coprocessor operation left mid-flight, since the coprocessor has no reset. Goes to IDLE next cycle.
  - IDLE: req_ready=1. On req_valid, latch opcode/op0/op1 into copro_* registers and go to WAIT; timeout counter cleared.
  - WAIT: copro_valid=1; copro_opcode/op0/op1 held stable; counter increments each cycle.
    - copro_complete=1: capture copro_result into rsp_result, rsp_err=0, go to ACK.
    - Otherwise, when TIMEOUT!=0 and counter reaches TIMEOUT-1: rsp_result=0, rsp_err=1, go to ACK.
    - If complete and timeout expiry occur in the same cycle, complete wins (err=0).
  - ACK: copro_valid=0, copro_accept=1 for exactly one cycle, then go to RESP.
  - RESP: rsp_valid=1; rsp_result/rsp_err held. On rsp_ready, go to IDLE and drop rsp_valid.
- Latency:
  - req handshake at edge E → copro_valid high from E+1.
  - copro_complete sampled at edge C → copro_accept high in cycle C+1 → rsp_valid high from C+2.
  - Minimum turnaround: next req accepted the cycle after the rsp handshake.
- Protocol rules:
  - copro_valid and copro_accept are never high in the same cycle.
  - copro_valid never rises in the cycle following an accept-less abort; every WAIT exit passes through ACK.
- req_valid outside IDLE is ignored (req_ready=0). rsp_ready outside RESP is ignored.
- rst_n low in any state, including mid-WAIT: outputs go to 0 at the next edge and the block re-enters FLUSH. The stale coprocessor operation is therefore always released.
- Counter width is clog2(TIMEOUT+1); it saturates and does not wrap.

Optional Feature:
Macro FLOAT_COPRO_PERF_EN.
- Defined: adds outputs perf_ops[31:0] and perf_cycles[31:0], both cleared by reset.
  - perf_ops increments on each ACK entered via complete.
  - perf_cycles increments every cycle spent in WAIT.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Add, real coprocessor (t_add=3): op0=0x3FC00000 (1.5), op1=0x40100000 (2.25) → rsp_result=0x40700000, rsp_err=0, exactly one copro_accept pulse.
- Mul then div back-to-back, rsp_ready tied 1:
  - 0x40000000×0x40400000 → 0x40C00000.
  - 0x3F800000/0x40800000 → 0x3E800000.
  - Second req_ready rises the cycle after the first rsp handshake.
- Timeout, TIMEOUT=16, stub responder never completes → after 16 WAIT cycles: accept pulse, rsp_valid with rsp_result=0, rsp_err=1.
- Backpressure: rsp_ready low 5 cycles in RESP → rsp_valid/rsp_result stable; req_ready=0; req_valid pulses ignored.
- Reset mid-WAIT: rst_n low 1 cycle at WAIT cycle 1 → outputs 0, then FLUSH accept pulse; a fresh add 1.5+2.25 afterwards returns 0x40700000.
- FLOAT_COPRO_PERF_EN defined: after the two ops of the back-to-back scenario → perf_ops=2; perf_cycles equals the summed WAIT cycles.
